axi_wr_master: RTL and testbench
================================

Name: axi_wr_master

Overview:
- AXI write master that drives the write address, write data and write response channels of the AXI slave.
- Takes one burst command plus a beat-data stream from a local client.
- Validates the command against AXI burst rules, issues AW and W concurrently, collects B, and returns a single completion response to the client.
- Handles one outstanding burst at a time.

Parameters:
- ADDR_BITS, 32, address width
- DATA_BITS, 32, data width (power of two, >=8)
- LEN_BITS, 8, burst length field width
- SIZE_BITS, 3, burst size field width
- TIMEOUT_CYCLES, 1024, B-channel watchdog limit (used only with the optional feature)

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous active-high reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accept
- cmd_addr  in  ADDR_BITS  burst start address
- cmd_len  in  LEN_BITS  beats-1
- cmd_size  in  SIZE_BITS  log2 bytes per beat
- cmd_burst  in  2  00 FIXED, 01 INCR, 10 WRAP
- wd_valid  in  1  client beat valid
- wd_ready  out  1  client beat accept
- wd_data  in  DATA_BITS  beat data
- wd_strb  in  DATA_BITS/8  beat byte strobes
- done_valid  out  1  one-cycle completion pulse
- done_resp  out  2  completion response
- busy  out  1  burst in progress
- aw_valid  out  1  AXI AW valid
- aw_ready  in  1  AXI AW ready
- aw_addr  out  ADDR_BITS  AXI AW address
- aw_len  out  LEN_BITS  AXI AW length
- aw_size  out  SIZE_BITS  AXI AW size
- aw_burst  out  2  AXI AW burst type
- aw_cache  out  4  AXI AW cache, constant 4'b0011
- w_valid  out  1  AXI W valid
- w_ready  in  1  AXI W ready
- w_data  out  DATA_BITS  AXI W data
- w_strb  out  DATA_BITS/8  AXI W strobes
- w_last  out  1  AXI W last beat
- b_valid  in  1  AXI B valid
- b_ready  out  1  AXI B ready
- b_resp  in  2  AXI B response

Behaviour:
- All state is clocked on rising aclk. areset is sampled synchronously.
- While areset is high, and on the first cycle after it, all valid/ready outputs are 0: aw_valid, w_valid, b_ready, wd_ready, done_valid, busy, cmd_ready. done_resp=0, state=IDLE.
- cmd_ready=1 only in IDLE with areset low.
- FSM states: IDLE, CHECK, XFER, RESP, DONE.
- IDLE:
  - On cmd_valid&cmd_ready, latch addr/len/size/burst, clear beat_cnt and aw_done, go to CHECK.
- CHECK (one cycle, no bus activity): compute err, where err = any of:
  - burst==2'b11
  - (1<<size) > DATA_BITS/8
  - WRAP with len not in {1,3,7,15}
  - WRAP with addr not aligned to (1<<size)
  - INCR with addr[11:0] + ((len+1)<<size) > 4096 (4KB crossing; 13-bit arithmetic)
  - err=1: done_resp<=2'b10 and go to DONE.
  - err=0: go to XFER.
- XFER:
  - aw_valid=!aw_done, with aw_* from the latched command. aw_done set on aw_valid&aw_ready.
  - W is a combinational passthrough: w_valid=wd_valid, wd_ready=w_ready, w_data/w_strb=wd_data/wd_strb, w_last=(beat_cnt==len_q). All are gated to 0 outside XFER and after the last beat.
  - W beats may complete before, with, or after the AW handshake.
  - beat_cnt increments on each w_valid&w_ready.
  - Leave XFER once aw_done (or an AW handshake this cycle) and the last beat handshake have both occurred; they may be the same cycle. Go to RESP.
- RESP:
  - b_ready=1. On b_valid, done_resp<=b_resp, go to DONE.
  - b_valid outside RESP is not accepted (b_ready=0).
- DONE:
  - done_valid=1 for exactly one cycle, then IDLE. cmd_ready rises the cycle after DONE.
- busy=1 in every state except IDLE.
- Latency: command accept at cycle 0; aw_valid first high at cycle 2. Minimum len=0 burst with always-ready slave: accept at 0, AW and W at 2, b_ready at 3, done_valid at 5 if b_valid is present at 3.
- aw_* held stable while aw_valid=1 and not ready. w_* follow wd_* (the client must hold data while wd_valid=1 and not wd_ready).
- Reset mid-burst: all outputs drop to reset values at the next edge; no done pulse; the partial burst is abandoned.

Optional Feature:
- Macro: AXI_WR_TIMEOUT_EN.
- Defined: a counter clears on entry to RESP and increments each RESP cycle without b_valid. On reaching TIMEOUT_CYCLES-1, set done_resp<=2'b11 and go to DONE. b_ready drops on that exit.
- Undefined: RESP waits indefinitely and no counter logic is synthesised.

Test Plan:
- INCR addr=0x100 len=0 size=2, all ready, b_resp=00 -> one AW (len 0), one W beat with w_last=1, done_valid at cycle 5 with done_resp=00.
- INCR addr=0x200 len=3 size=2; aw_ready delayed 5 cycles; w_ready toggles 1/0 -> exactly 4 W beats in client order, w_last only on the 4th, AW stable until accepted, one done pulse.
- WRAP len=2 -> no aw_valid/w_valid ever, done_resp=10. WRAP addr=0x102 size=2 len=3 -> done_resp=10.
- INCR addr=0xFF8 len=3 size=2 -> 4KB crossing, done_resp=10, no bus activity. Same burst at addr=0xFF0 -> accepted and completes.
- len=1 burst with b_resp=2'b10 -> done_resp=10. Assert areset in XFER after beat 1 -> next cycle all valids 0, no done_valid, cmd_ready=1 one cycle after reset release.
- With AXI_WR_TIMEOUT_EN and TIMEOUT_CYCLES=16, b_valid never asserted -> done_resp=11 after 16 RESP cycles, then IDLE.

Source files
------------

// File: rtl/axi_wr_master.sv
// Single-outstanding AXI write master: validates a client burst command, drives AW/W, collects B.
// Define AXI_WR_TIMEOUT_EN to add a B-channel watchdog that completes with resp 2'b11.
module axi_wr_master #(
  parameter int unsigned ADDR_BITS      = 32,
  parameter int unsigned DATA_BITS      = 32,
  parameter int unsigned LEN_BITS       = 8,
  parameter int unsigned SIZE_BITS      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [ADDR_BITS-1:0]   cmd_addr,
  input  logic [LEN_BITS-1:0]    cmd_len,
  input  logic [SIZE_BITS-1:0]   cmd_size,
  input  logic [1:0]             cmd_burst,
  input  logic                   wd_valid,
  output logic                   wd_ready,
  input  logic [DATA_BITS-1:0]   wd_data,
  input  logic [DATA_BITS/8-1:0] wd_strb,
  output logic                   done_valid,
  output logic [1:0]             done_resp,
  output logic                   busy,
  output logic                   aw_valid,
  input  logic                   aw_ready,
  output logic [ADDR_BITS-1:0]   aw_addr,
  output logic [LEN_BITS-1:0]    aw_len,
  output logic [SIZE_BITS-1:0]   aw_size,
  output logic [1:0]             aw_burst,
  output logic [3:0]             aw_cache,
  output logic                   w_valid,
  input  logic                   w_ready,
  output logic [DATA_BITS-1:0]   w_data,
  output logic [DATA_BITS/8-1:0] w_strb,
  output logic                   w_last,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic [1:0]             b_resp
);

  localparam int unsigned STRB_BITS = DATA_BITS / 8;
  localparam logic [SIZE_BITS-1:0] SIZE_MAX = SIZE_BITS'($clog2(STRB_BITS));

  if (TIMEOUT_CYCLES < 2 || DATA_BITS < 8) begin : g_bad_params
    $error("axi_wr_master: TIMEOUT_CYCLES must be >= 2 and DATA_BITS >= 8");
  end

  typedef enum logic [2:0] {IDLE, CHECK, XFER, RESP, DONE} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [LEN_BITS-1:0]    len_q, len_d;
  logic [SIZE_BITS-1:0]   size_q, size_d;
  logic [1:0]             burst_q, burst_d;
  logic [LEN_BITS-1:0]    beat_cnt_q, beat_cnt_d;
  logic                   aw_done_q, aw_done_d;
  logic                   w_done_q, w_done_d;
  logic [1:0]             done_resp_q, done_resp_d;
  logic                   done_valid_q, done_valid_d;

`ifdef AXI_WR_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
`endif

  logic                   err;
  logic                   w_active;
  logic                   aw_hs, w_hs, last_hs;
  logic [31:0]            incr_end;
  logic [ADDR_BITS-1:0]   align_mask;
  logic                   wrap_len_ok;

  always_ff @(posedge aclk) begin
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      addr_q       <= '0;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      beat_cnt_q   <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      done_resp_q  <= '0;
      done_valid_q <= 1'b0;
`ifdef AXI_WR_TIMEOUT_EN
      to_cnt_q     <= '0;
`endif
    end else begin
      addr_q       <= addr_d;
      len_q        <= len_d;
      size_q       <= size_d;
      burst_q      <= burst_d;
      beat_cnt_q   <= beat_cnt_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      done_resp_q  <= done_resp_d;
      done_valid_q <= done_valid_d;
`ifdef AXI_WR_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
`endif
    end
  end

  always_comb begin
    incr_end    = 32'(addr_q[11:0]) + ((32'(len_q) + 32'd1) << size_q);
    align_mask  = ~({ADDR_BITS{1'b1}} << size_q);
    wrap_len_ok = (len_q == LEN_BITS'(1)) || (len_q == LEN_BITS'(3)) ||
                  (len_q == LEN_BITS'(7)) || (len_q == LEN_BITS'(15));
    err = (burst_q == 2'b11) || (size_q > SIZE_MAX) ||
          ((burst_q == 2'b10) && !wrap_len_ok) ||
          ((burst_q == 2'b10) && ((addr_q & align_mask) != '0)) ||
          ((burst_q == 2'b01) && (incr_end > 32'd4096));
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    size_d       = size_q;
    burst_d      = burst_q;
    beat_cnt_d   = beat_cnt_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    done_resp_d  = done_resp_q;
    done_valid_d = (state_q == DONE);
`ifdef AXI_WR_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d      = cmd_addr;
          len_d       = cmd_len;
          size_d      = cmd_size;
          burst_d     = cmd_burst;
          beat_cnt_d  = '0;
          aw_done_d   = 1'b0;
          w_done_d    = 1'b0;
          done_resp_d = '0;
          state_d     = CHECK;
        end
      end
      CHECK: begin
        if (err) begin
          done_resp_d = 2'b10;
          state_d     = DONE;
        end else begin
          state_d     = XFER;
        end
      end
      XFER: begin
        aw_done_d  = aw_done_q | aw_hs;
        w_done_d   = w_done_q | last_hs;
        beat_cnt_d = beat_cnt_q + LEN_BITS'(w_hs);
`ifdef AXI_WR_TIMEOUT_EN
        to_cnt_d   = '0;
`endif
        if (aw_done_d && w_done_d) state_d = RESP;
      end
      RESP: begin
        if (b_valid) begin
          done_resp_d = b_resp;
          state_d     = DONE;
        end
`ifdef AXI_WR_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          done_resp_d = 2'b11;
          state_d     = DONE;
        end else begin
          to_cnt_d    = to_cnt_q + 1'b1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // done_valid is registered off DONE, so the pulse lands in the first IDLE cycle.
  always_comb begin
    w_active   = (state_q == XFER) && !w_done_q && !areset;
    cmd_ready  = (state_q == IDLE) && !areset;
    busy       = (state_q != IDLE) && !areset;
    aw_valid   = (state_q == XFER) && !aw_done_q && !areset;
    aw_addr    = addr_q;
    aw_len     = len_q;
    aw_size    = size_q;
    aw_burst   = burst_q;
    aw_cache   = 4'b0011;
    w_valid    = w_active && wd_valid;
    wd_ready   = w_active && w_ready;
    w_data     = w_active ? wd_data : '0;
    w_strb     = w_active ? wd_strb : '0;
    w_last     = w_active && (beat_cnt_q == len_q);
    b_ready    = (state_q == RESP) && !areset;
    done_valid = done_valid_q && !areset;
    done_resp  = done_resp_q;
    aw_hs      = aw_valid && aw_ready;
    w_hs       = w_valid && w_ready;
    last_hs    = w_hs && w_last;
  end

endmodule

// File: tb/tb_axi_wr_master.sv
// Directed self-checking bench for axi_wr_master with a cycle-scripted slave and client.
module tb_axi_wr_master;

  logic        aclk = 1'b0;
  logic        areset;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic        wd_valid, wd_ready;
  logic [31:0] wd_data;
  logic [3:0]  wd_strb;
  logic        done_valid;
  logic [1:0]  done_resp;
  logic        busy;
  logic        aw_valid, aw_ready;
  logic [31:0] aw_addr;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;
  logic [3:0]  aw_cache;
  logic        w_valid, w_ready;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        w_last;
  logic        b_valid, b_ready;
  logic [1:0]  b_resp;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 aclk = ~aclk;

  axi_wr_master #(
    .ADDR_BITS(32), .DATA_BITS(32), .LEN_BITS(8), .SIZE_BITS(3), .TIMEOUT_CYCLES(16)
  ) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .done_valid(done_valid), .done_resp(done_resp), .busy(busy),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_len(aw_len),
    .aw_size(aw_size), .aw_burst(aw_burst), .aw_cache(aw_cache),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_size = '0; cmd_burst = '0;
    wd_valid = 1'b0; wd_data = '0; wd_strb = '0;
    aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_resp = '0;
  endtask

  // aw_rdy/b_cyc: cycle (from command issue) from which the slave holds that signal high
  task automatic run_burst(input string name, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int aw_rdy,
                           input bit wtog, input int b_cyc, input logic [1:0] bresp,
                           input bit exp_err, input logic [1:0] exp_resp, input int exp_done);
    int k = 0, aw_hs = 0, aw_vld = 0, w_vld = 0, aw_bad = 0, w_bad = 0;
    int beats = 0, b_hs = 0, done_n = 0, done_at = -1, first_aw = -1;
    logic [1:0] resp_seen = 2'bxx;
    bit accepted = 1'b0;
    bit exp_b;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(posedge aclk); #1;
      cmd_valid = !accepted; cmd_addr = addr; cmd_len = len; cmd_size = size; cmd_burst = burst;
      aw_ready  = (cyc >= aw_rdy);
      w_ready   = wtog ? (cyc % 2 == 1) : 1'b1;
      wd_valid  = (k <= int'(len));
      wd_data   = {addr[15:0], 8'h5A, 8'(k)};
      wd_strb   = 4'(k + 1);
      b_valid   = (cyc >= b_cyc);
      b_resp    = bresp;
      @(negedge aclk);
      if (cyc == 0) check({name, ".cmd_ready"}, cmd_ready, 1);
      if (cyc == 1) check({name, ".busy"}, busy, 1);
      if (cmd_valid && cmd_ready) accepted = 1'b1;
      if (aw_valid) begin
        aw_vld++;
        if (first_aw < 0) first_aw = cyc;
        if ({aw_addr, aw_len, aw_size, aw_burst, aw_cache} !== {addr, len, size, burst, 4'b0011})
          aw_bad++;
        if (aw_ready) aw_hs++;
      end
      if (w_valid) begin
        w_vld++;
        if (w_data !== wd_data || w_strb !== wd_strb || w_last !== (k == int'(len)) ||
            wd_ready !== w_ready)
          w_bad++;
        if (w_ready) begin beats++; k++; end
      end
      if (b_valid && b_ready) b_hs++;
      if (done_valid) begin done_n++; done_at = cyc; resp_seen = done_resp; end
      if (done_n > 0 && cyc >= done_at + 2) break;
    end
    idle_inputs();
    exp_b = !exp_err && (exp_resp != 2'b11);
    check({name, ".done_count"}, done_n, 1);
    check({name, ".done_resp"}, resp_seen, exp_resp);
    check({name, ".done_cycle"}, done_at, exp_done);
    check({name, ".aw_handshakes"}, aw_hs, exp_err ? 0 : 1);
    check({name, ".w_beats"}, beats, exp_err ? 0 : int'(len) + 1);
    check({name, ".aw_fields_bad"}, aw_bad, 0);
    check({name, ".w_beats_bad"}, w_bad, 0);
    check({name, ".b_handshakes"}, b_hs, exp_b ? 1 : 0);
    if (exp_err) check({name, ".bus_activity"}, aw_vld + w_vld, 0);
    else         check({name, ".first_aw_cycle"}, first_aw, 2);
  endtask

  task automatic reset_mid_burst();
    @(posedge aclk); #1;
    cmd_valid = 1'b1; cmd_addr = 32'h400; cmd_len = 8'd3; cmd_size = 3'd2; cmd_burst = 2'b01;
    w_ready = 1'b1;
    @(posedge aclk); #1;
    cmd_valid = 1'b0;
    @(posedge aclk); #1;
    wd_valid = 1'b1; wd_data = 32'hCAFE_0001; wd_strb = 4'hF;
    @(negedge aclk);
    check("rst.beat1_valid", {w_valid, w_last, busy}, 3'b101);
    @(posedge aclk); #1;
    areset = 1'b1; b_valid = 1'b1; wd_data = 32'hCAFE_0002;
    @(posedge aclk); #1;
    check("rst.outputs_in_reset",
          {aw_valid, w_valid, b_ready, wd_ready, done_valid, busy, cmd_ready}, 7'b0);
    check("rst.done_resp", done_resp, 2'b00);
    areset = 1'b0;
    idle_inputs();
    @(posedge aclk); #1;
    check("rst.after_release",
          {cmd_ready, busy, aw_valid, w_valid, b_ready, done_valid}, 6'b100000);
    @(posedge aclk); #1;
    check("rst.no_done_pulse", {done_valid, busy}, 2'b00);
  endtask

  initial begin
    idle_inputs();
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    check("reset.outputs",
          {aw_valid, w_valid, b_ready, wd_ready, done_valid, busy, cmd_ready}, 7'b0);
    check("reset.done_resp", done_resp, 2'b00);
    areset = 1'b0;
    @(negedge aclk);
    check("reset.idle_after_release", {cmd_ready, busy}, 2'b10);

    run_burst("incr_len0",   32'h100, 8'd0, 3'd2, 2'b01, 0,    1'b0, 0,    2'b00, 1'b0, 2'b00, 5);
    run_burst("incr_len3_bp",32'h200, 8'd3, 3'd2, 2'b01, 7,    1'b1, 0,    2'b00, 1'b0, 2'b00, 12);
    run_burst("wrap_len2",   32'h100, 8'd2, 3'd2, 2'b10, 0,    1'b0, 1000, 2'b00, 1'b1, 2'b10, 3);
    run_burst("wrap_unalign",32'h102, 8'd3, 3'd2, 2'b10, 0,    1'b0, 1000, 2'b00, 1'b1, 2'b10, 3);
    run_burst("wrap_ok",     32'h104, 8'd3, 3'd2, 2'b10, 0,    1'b0, 0,    2'b00, 1'b0, 2'b00, 8);
    run_burst("incr_4k_x",   32'hFF8, 8'd3, 3'd2, 2'b01, 0,    1'b0, 1000, 2'b00, 1'b1, 2'b10, 3);
    run_burst("incr_4k_edge",32'hFF0, 8'd3, 3'd2, 2'b01, 0,    1'b0, 0,    2'b00, 1'b0, 2'b00, 8);
    run_burst("bresp_slverr",32'h300, 8'd1, 3'd2, 2'b01, 0,    1'b0, 6,    2'b10, 1'b0, 2'b10, 8);
    run_burst("fixed_len1",  32'h500, 8'd1, 3'd1, 2'b00, 0,    1'b0, 0,    2'b00, 1'b0, 2'b00, 6);
    run_burst("size_too_big",32'h600, 8'd0, 3'd3, 2'b01, 0,    1'b0, 1000, 2'b00, 1'b1, 2'b10, 3);
    run_burst("burst_rsvd",  32'h700, 8'd0, 3'd2, 2'b11, 0,    1'b0, 1000, 2'b00, 1'b1, 2'b10, 3);
`ifdef AXI_WR_TIMEOUT_EN
    run_burst("b_timeout",   32'h800, 8'd0, 3'd2, 2'b01, 0,    1'b0, 1000, 2'b00, 1'b0, 2'b11, 20);
`else
    run_burst("b_late",      32'h800, 8'd0, 3'd2, 2'b01, 0,    1'b0, 45,   2'b01, 1'b0, 2'b01, 47);
`endif

    reset_mid_burst();
    run_burst("post_reset",  32'h900, 8'd0, 3'd2, 2'b01, 0,    1'b0, 0,    2'b00, 1'b0, 2'b00, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
